sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8x9 register FIFO.
//  Adds configurable width/depth, full/empty and programmable almost-full/almost-empty flags,
//  occupancy count, overflow/underflow error pulses, synchronous flush and a registered read port with valid.
//  Sits between a producer and a consumer in the same clock domain, e.g. datapath stage buffering.
// PARAMETERS
//  DATA_W     9  data word width in bits (>=1)
//  DEPTH      8  number of entries; power of two, >=2
//  AF_LEVEL   6  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL   2  almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1                 clock, all logic on rising edge
//  rst           in   1                 synchronous, active-high reset
//  flush         in   1                 synchronous clear of pointers and count; storage contents untouched
//  wr_en         in   1                 write request
//  wr_data       in   DATA_W            write data
//  rd_en         in   1                 read request
//  rd_data       out  DATA_W            registered read data
//  rd_valid      out  1                 1-cycle pulse: rd_data holds a newly popped word
//  count         out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  full          out  1                 count == DEPTH
//  empty         out  1                 count == 0
//  almost_full   out  1                 count >= AF_LEVEL
//  almost_empty  out  1                 count <= AE_LEVEL
//  overflow      out  1                 1-cycle pulse: wr_en while full (write dropped)
//  underflow     out  1                 1-cycle pulse: rd_en while empty (read dropped)
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr/rd pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0;
//    hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0). Storage array not reset.
//  - Priority per edge: rst > flush > normal operation. flush: pointers/count -> 0, rd_valid=0,
//    overflow=underflow=0, rd_data holds last value; wr_en/rd_en in the flush cycle ignored.
//  - Pointers: $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally; count tracked separately.
//  - Write accept: wr_acc = wr_en & ~full (full = value before the edge). Stores wr_data at wr_ptr, wr_ptr++.
//  - Read accept: rd_acc = rd_en & ~empty. At the edge rd_data <= mem[rd_ptr], rd_ptr++, rd_valid <= 1;
//    otherwise rd_valid <= 0 and rd_data holds. Read latency: 1 clk from accepted rd_en to rd_valid.
//  - No fall-through: write into empty FIFO is readable the following cycle, never same cycle.
//  - Full and wr_en & rd_en: read accepted, write rejected (overflow pulses), count DEPTH -> DEPTH-1.
//  - Empty and wr_en & rd_en: write accepted, read rejected (underflow pulses), count 0 -> 1.
//  - Otherwise simultaneous accepted write and read: count unchanged, both pointers advance.
//  - count update: +1 (wr_acc only), -1 (rd_acc only), 0 (both/neither). Never exceeds DEPTH or goes below 0.
//  - full/empty/almost_* are combinational decodes of registered count; overflow/underflow registered,
//    asserted the cycle after the offending request, for one cycle per offending request.
//  - Rejected requests never modify memory, pointers or count.
// TESTING
//  1 Reset: rst=1 two cycles with wr_en=rd_en=1 -> count=0, empty=1, rd_data=0, rd_valid=0, no err pulses.
//  2 Fill/drain (DATA_W=9, DEPTH=8): write 0x101..0x108 -> full=1, count=8, almost_full from 6th write;
//    9th write 0x1FF -> overflow pulse, count stays 8; read 8 -> rd_data 0x101..0x108 in order, each 1 clk
//    after rd_en with rd_valid=1; then empty=1, almost_empty from count<=2.
//  3 Wrap: 200 cycles random wr_en/rd_en (no overflow) vs scoreboard model -> data order and count match
//    every cycle across many pointer wraps.
//  4 Boundaries: at count=8 assert wr_en&rd_en -> count=7, overflow=1, head word output; at count=0
//    wr_en&rd_en -> count=1, underflow=1, rd_valid=0.
//  5 Flush mid-stream: count=5, flush=1 with wr_en=rd_en=1 -> next cycle count=0, empty=1, rd_valid=0,
//    rd_data unchanged; subsequent write 0x0AA then read -> rd_data=0x0AA.
//  6 Parameter sweep: DEPTH=2,16 and DATA_W=1,32 rerun tests 2-4; AF_LEVEL=DEPTH, AE_LEVEL=0 flag edges correct.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with registered read port
//
// Purpose: buffers words between a producer and a consumer in one clock domain.
//   Occupancy is tracked in its own counter. The pointers are only log2(DEPTH)
//   bits wide, so they cannot tell full from empty on their own.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   flush         in   synchronous clear of pointers/count; storage untouched
//   wr_en/wr_data in   write request and data
//   rd_en         in   read request
//   rd_data       out  registered read data, holds between pops
//   rd_valid      out  one-cycle pulse, rd_data carries a freshly popped word
//   count         out  occupancy 0..DEPTH
//   full/empty    out  count == DEPTH / count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   overflow      out  one-cycle pulse after a write was dropped because the FIFO was full
//   underflow     out  one-cycle pulse after a read was dropped because the FIFO was empty
module sync_fifo_param #(
  parameter int DATA_W   = 9,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  // Status flags decode the registered count, so they settle right after the edge.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));

  // Accepts use the flags from before the edge. This makes a simultaneous
  // push/pop on a full FIFO reject the push, and on an empty FIFO reject the pop.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (flush) begin
      // rd_data is deliberately left alone; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      overflow_d  = wr_en & full;
      underflow_d = rd_en & empty;

      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset. It is written only by an accepted push that is not
  // overridden by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [8:0] wr_data;
  logic       rd_en;
  logic [8:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  // DEPTH=2, DATA_W=1 instance exercising the AF_LEVEL=DEPTH / AE_LEVEL=0 extremes
  logic       s_flush, s_wr_en, s_wr_data, s_rd_en;
  logic       s_rd_data, s_rd_valid;
  logic [1:0] s_count;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(9), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(1), .DEPTH(2), .AF_LEVEL(2), .AE_LEVEL(0)) dut_small (
    .clk(clk), .rst(rst), .flush(s_flush),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .count(s_count),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .overflow(s_ovf), .underflow(s_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [8:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
  endtask

  logic [8:0] q[$];
  logic [8:0] popped;
  logic       wacc, racc;

  initial begin
    rst = 1'b1; flush = 1'b0;
    s_flush = 1'b0; s_wr_en = 1'b1; s_wr_data = 1'b1; s_rd_en = 1'b1;
    drive(1'b1, 9'h155, 1'b1);

    // Reset held two cycles with both requests active
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_small_count", 32'(s_count), 32'd0);

    rst = 1'b0;
    s_wr_en = 1'b0; s_rd_en = 1'b0;

    // Fill to 8 entries
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 9'(9'h100 + i), 1'b0);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      chk("fill_ovf", 32'(overflow), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);

    drive(1'b1, 9'h1FF, 1'b0);
    step();
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    drive(1'b0, 9'h000, 1'b0);
    step();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 9'h000, 1'b1);
      step();
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data", 32'(rd_data), 32'(9'h100 + i));
      chk("drain_count", 32'(count), 32'(8 - i));
      chk("drain_ae", 32'(almost_empty), (8 - i <= 2) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 9'h000, 1'b0);
    step();
    chk("drain_idle_valid", 32'(rd_valid), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_hold", 32'(rd_data), 32'h108);

    // Boundary: full with simultaneous push/pop
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 9'(9'h120 + i), 1'b0);
      step();
    end
    chk("bnd_full", 32'(full), 32'd1);
    drive(1'b1, 9'h1EE, 1'b1);
    step();
    chk("bnd_full_count", 32'(count), 32'd7);
    chk("bnd_full_ovf", 32'(overflow), 32'd1);
    chk("bnd_full_valid", 32'(rd_valid), 32'd1);
    chk("bnd_full_data", 32'(rd_data), 32'h121);
    for (int i = 2; i <= 8; i++) begin
      drive(1'b0, 9'h000, 1'b1);
      step();
      chk("bnd_drain_data", 32'(rd_data), 32'(9'h120 + i));
    end
    chk("bnd_empty", 32'(empty), 32'd1);

    // Boundary: empty with simultaneous push/pop
    drive(1'b1, 9'h055, 1'b1);
    step();
    chk("bnd_empty_count", 32'(count), 32'd1);
    chk("bnd_empty_unf", 32'(underflow), 32'd1);
    chk("bnd_empty_valid", 32'(rd_valid), 32'd0);
    drive(1'b0, 9'h000, 1'b1);
    step();
    chk("bnd_empty_unf_clear", 32'(underflow), 32'd0);
    chk("bnd_empty_data", 32'(rd_data), 32'h055);

    // Flush mid-stream with both requests active
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'(9'h010 + i), 1'b0);
      step();
    end
    chk("flush_pre_count", 32'(count), 32'd5);
    flush = 1'b1;
    drive(1'b1, 9'h1AB, 1'b1);
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_valid", 32'(rd_valid), 32'd0);
    chk("flush_hold", 32'(rd_data), 32'h055);
    drive(1'b1, 9'h0AA, 1'b0);
    step();
    drive(1'b0, 9'h000, 1'b1);
    step();
    chk("flush_after_valid", 32'(rd_valid), 32'd1);
    chk("flush_after_data", 32'(rd_data), 32'h0AA);
    chk("flush_after_empty", 32'(empty), 32'd1);

    // Random traffic against a queue model, never overflowing
    for (int c = 0; c < 200; c++) begin
      wacc = ($urandom_range(0, 1) == 1) && (q.size() < 8);
      racc = 1'b0;
      rd_en = ($urandom_range(0, 1) == 1);
      wr_en = wacc;
      wr_data = 9'($urandom_range(0, 511));
      if (rd_en && q.size() > 0) begin
        racc = 1'b1;
        popped = q.pop_front();
      end
      if (wacc) q.push_back(wr_data);
      step();
      chk("rand_count", 32'(count), 32'(q.size()));
      chk("rand_valid", 32'(rd_valid), 32'(racc));
      if (racc) chk("rand_data", 32'(rd_data), 32'(popped));
    end
    drive(1'b0, 9'h000, 1'b0);

    // Small instance: DEPTH=2, AF_LEVEL=2, AE_LEVEL=0
    chk("s_empty", 32'(s_empty), 32'd1);
    chk("s_ae0", 32'(s_ae), 32'd1);
    s_wr_en = 1'b1; s_wr_data = 1'b1;
    step();
    chk("s_count1", 32'(s_count), 32'd1);
    chk("s_ae1", 32'(s_ae), 32'd0);
    chk("s_af1", 32'(s_af), 32'd0);
    s_wr_data = 1'b0;
    step();
    chk("s_full", 32'(s_full), 32'd1);
    chk("s_af2", 32'(s_af), 32'd1);
    s_wr_data = 1'b1;
    step();
    chk("s_ovf", 32'(s_ovf), 32'd1);
    chk("s_ovf_count", 32'(s_count), 32'd2);
    s_wr_en = 1'b0; s_rd_en = 1'b1;
    step();
    chk("s_rd1", 32'(s_rd_data), 32'd1);
    chk("s_af_drop", 32'(s_af), 32'd0);
    step();
    chk("s_rd2", 32'(s_rd_data), 32'd0);
    chk("s_rd2_valid", 32'(s_rd_valid), 32'd1);
    chk("s_empty2", 32'(s_empty), 32'd1);
    chk("s_ae2", 32'(s_ae), 32'd1);
    step();
    chk("s_unf", 32'(s_unf), 32'd1);
    chk("s_unf_valid", 32'(s_rd_valid), 32'd0);
    s_rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
